// File: rtl/alu4.sv
// Registered add/subtract unit: one operation accepted per valid cycle,
// result and zero/carry/overflow flags appear one clock later.
module alu4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SELECT,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             out_valid
);

    // Handshake: in_valid qualifies A/B/SELECT on a rising edge; there is no
    // ready, so every valid cycle is accepted and out_valid pulses exactly
    // one cycle later for each accepted operation.

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry_next;
    logic             overflow_next;

    always_comb begin
        b_eff  = SELECT ? B : ~B;
        sum    = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~SELECT};
        result = sum[WIDTH-1:0];
        // Subtract reports borrow, which is the inverted carry-out of A + ~B + 1.
        carry_next = SELECT ? sum[WIDTH] : ~sum[WIDTH];
        // Comparing against the effective operand covers both add and subtract.
        overflow_next = (A[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            Zero      <= 1'b1;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out      <= result;
                Zero     <= (result == '0);
                Carry    <= carry_next;
                Overflow <= overflow_next;
            end
        end
    end

endmodule

// File: tb/tb_alu4.sv
// Directed bench for alu4: vector table streamed back-to-back plus
// hand-written reset, hold and mid-stream reset sequences.
module tb_alu4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             out_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sel;
        logic [WIDTH-1:0] exp_out;
        logic             exp_zero;
        logic             exp_carry;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[13];

    alu4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .SELECT    (sel),
        .in_valid  (in_valid),
        .Out       (out),
        .Zero      (zero),
        .Carry     (carry),
        .Overflow  (overflow),
        .out_valid (out_valid)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [WIDTH-1:0] e_out, input logic e_zero,
                             input logic e_carry, input logic e_ovf, input logic e_valid);
        check({name, ".out"},       32'(out),       32'(e_out));
        check({name, ".zero"},      32'(zero),      32'(e_zero));
        check({name, ".carry"},     32'(carry),     32'(e_carry));
        check({name, ".overflow"},  32'(overflow),  32'(e_ovf));
        check({name, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    endtask

    // driver: present inputs on the falling edge, then sample #1 after the rising edge
    task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] da,
                         input logic [WIDTH-1:0] db, input logic ds);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = da;
        b        = db;
        sel      = ds;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            a        b        sel   out      z     c     ov
        vecs[0]  = '{4'b0010, 4'b0011, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0111, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{4'b0011, 4'b1000, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b1001, 4'b0110, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'b0010;
        b        = 4'b0011;
        sel      = 1'b1;

        // reset held two cycles with a valid operation pending: reset wins
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'b0010, 4'b0011, 1'b1);
            check_all($sformatf("reset%0d", i), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // table streamed back-to-back: out_valid stays high every cycle
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sel);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero,
                      vecs[i].exp_carry, vecs[i].exp_ovf, 1'b1);
        end

        // hold: operands toggle with in_valid low, outputs stay on the last result
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            check_all($sformatf("hold%0d", i), 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // single operation, then idle: out_valid pulses for exactly one cycle
        drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1);
        check_all("pulse_op", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'b0111, 4'b0001, 1'b1);
        check_all("pulse_idle", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset mid-stream: prior result visible one cycle, then cleared
        drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b1);
        check_all("mid_op", 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1);
        check_all("mid_rst0", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'b1000, 4'b0001, 1'b0);
        check_all("mid_rst1", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'b1000, 4'b0001, 1'b0);
        check_all("post_rst_idle", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // first operation after reset
        drive(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b0);
        check_all("post_rst_op", 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_all("post_rst_hold", 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
